// File: rtl/dvp_rgb565_packer.sv
// DVP byte-stream to RGB565 pixel packer feeding the Sobel stage.
// Frames the stream to IMG_WIDTH x IMG_HEIGHT and flags malformed lines and frames.
module dvp_rgb565_packer #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 48,
    parameter bit HI_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_byte_en,
    input  logic [7:0]  cam_data,
    output logic        vsync_out,
    output logic        href_out,
    output logic [15:0] pixel_out,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int COL_W = $clog2(IMG_WIDTH + 2);
    localparam int ROW_W = $clog2(IMG_HEIGHT + 1);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, DONE} state_t;

    state_t             state;
    logic               vsync_d;
    logic               href_d;
    logic               phase;
    logic               got_byte;
    logic [7:0]         stored;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

    logic vsync_rise;
    logic vsync_fall;
    logic href_fall;
    logic byte_ok;

    assign vsync_rise = cam_vsync & ~vsync_d;
    assign vsync_fall = ~cam_vsync & vsync_d;
    assign href_fall  = ~cam_href & href_d;
    assign byte_ok    = cam_href & cam_byte_en;

    // col keeps counting past IMG_WIDTH (saturating) so over-long lines are detectable at line end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vsync_d    <= 1'b0;
            href_d     <= 1'b0;
            phase      <= 1'b0;
            got_byte   <= 1'b0;
            stored     <= 8'd0;
            col        <= '0;
            row        <= '0;
            vsync_out  <= 1'b0;
            href_out   <= 1'b0;
            pixel_out  <= 16'd0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            vsync_d    <= cam_vsync;
            href_d     <= cam_href;
            vsync_out  <= 1'b0;
            href_out   <= 1'b0;
            line_err   <= 1'b0;
            frame_done <= 1'b0;

            // frame_err shows the previous frame's verdict during the vsync_out cycle, then clears
            if (vsync_out) begin
                frame_err <= 1'b0;
            end

            if (vsync_rise) begin
                state     <= SYNC;
                vsync_out <= 1'b1;
                phase     <= 1'b0;
                got_byte  <= 1'b0;
                col       <= '0;
                row       <= '0;
                if (state == SYNC || state == ACTIVE) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SYNC: begin
                        if (vsync_fall) begin
                            state <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (byte_ok) begin
                            got_byte <= 1'b1;
                            if (!phase) begin
                                stored <= cam_data;
                                phase  <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                if (col < COL_W'(IMG_WIDTH)) begin
                                    href_out  <= 1'b1;
                                    pixel_out <= HI_FIRST ? {stored, cam_data} : {cam_data, stored};
                                end
                                if (col <= COL_W'(IMG_WIDTH)) begin
                                    col <= col + COL_W'(1);
                                end
                            end
                        end else if (href_fall && got_byte) begin
                            if (col != COL_W'(IMG_WIDTH) || phase) begin
                                line_err  <= 1'b1;
                                frame_err <= 1'b1;
                            end
                            col      <= '0;
                            phase    <= 1'b0;
                            got_byte <= 1'b0;
                            row      <= row + ROW_W'(1);
                            if (row == ROW_W'(IMG_HEIGHT - 1)) begin
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= IDLE;
                        if (byte_ok) begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
